qvga_frame_writer: RTL

//  Write side of the QVGA frame buffer; the VGA memory reader consumes what this block stores.

---
 rtl/qvga_frame_writer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/qvga_frame_writer.sv
// Write side of the QVGA frame buffer: packs an OV7670-style VSYNC/HREF byte stream
// into RGB565 pixels and issues single-cycle writes at y*H_PIX + x, clipped to the window.
`timescale 1ns/1ps

module qvga_frame_writer #(
    parameter int H_PIX   = 320,
    parameter int V_LINES = 240,
    parameter int ADDR_W  = 17
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              capture_en,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        data,
    output logic              we,
    output logic [ADDR_W-1:0] wAddr,
    output logic [15:0]       wData,
    output logic              frame_done,
    output logic              busy
);

    localparam int X_W = $clog2(H_PIX + 1);
    localparam int Y_W = $clog2(V_LINES + 1);
    localparam logic [X_W-1:0] X_LIM = X_W'(H_PIX);
    localparam logic [Y_W-1:0] Y_LIM = Y_W'(V_LINES);

    typedef enum logic [1:0] {IDLE, SYNC, ACTIVE} state_t;

    state_t            state_q, state_d;
    logic              vsync_dly_q, vsync_dly_d;
    logic              href_dly_q, href_dly_d;
    logic              phase_q, phase_d;
    logic [7:0]        byte0_q, byte0_d;
    logic [X_W-1:0]    x_q, x_d;
    logic [Y_W-1:0]    y_q, y_d;
    logic              line_px_q, line_px_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              frame_done_q, frame_done_d;
    logic [ADDR_W-1:0] pix_addr;

    // 320 = 256 + 64, so the default geometry needs only two shifts and an add.
    always_comb begin
        if (H_PIX == 320) begin
            pix_addr = (ADDR_W'(y_q) << 8) + (ADDR_W'(y_q) << 6) + ADDR_W'(x_q);
        end else begin
            pix_addr = ADDR_W'(y_q) * ADDR_W'(H_PIX) + ADDR_W'(x_q);
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d      = state_q;
        vsync_dly_d  = vsync;
        href_dly_d   = href;
        phase_d      = phase_q;
        byte0_d      = byte0_q;
        x_d          = x_q;
        y_d          = y_q;
        line_px_d    = line_px_q;
        we_d         = 1'b0;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        frame_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (capture_en && vsync) state_d = SYNC;
            end
            SYNC: begin
                if (vsync_dly_q && !vsync) begin
                    state_d   = ACTIVE;
                    x_d       = '0;
                    y_d       = '0;
                    phase_d   = 1'b0;
                    line_px_d = 1'b0;
                end
            end
            ACTIVE: begin
                // A vsync rise ends the frame and takes priority over any byte this cycle.
                if (vsync && !vsync_dly_q) begin
                    frame_done_d = 1'b1;
                    phase_d      = 1'b0;
                    state_d      = capture_en ? SYNC : IDLE;
                end else if (href) begin
                    if (!phase_q) begin
                        byte0_d = data;
                        phase_d = 1'b1;
                    end else begin
                        phase_d   = 1'b0;
                        line_px_d = 1'b1;
                        if (x_q < X_LIM && y_q < Y_LIM) begin
                            we_d    = 1'b1;
                            waddr_d = pix_addr;
                            wdata_d = {byte0_q, data};
                        end
                        if (x_q < X_LIM) x_d = x_q + X_W'(1);
                    end
                end else begin
                    phase_d = 1'b0;
                    if (href_dly_q) begin
                        x_d       = '0;
                        line_px_d = 1'b0;
                        if (line_px_q && y_q < Y_LIM) y_d = y_q + Y_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            vsync_dly_q  <= 1'b0;
            href_dly_q   <= 1'b0;
            phase_q      <= 1'b0;
            byte0_q      <= '0;
            x_q          <= '0;
            y_q          <= '0;
            line_px_q    <= 1'b0;
            we_q         <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            vsync_dly_q  <= vsync_dly_d;
            href_dly_q   <= href_dly_d;
            phase_q      <= phase_d;
            byte0_q      <= byte0_d;
            x_q          <= x_d;
            y_q          <= y_d;
            line_px_q    <= line_px_d;
            we_q         <= we_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign we         = we_q;
    assign wAddr      = waddr_q;
    assign wData      = wdata_q;
    assign frame_done = frame_done_q;
    assign busy       = (state_q == ACTIVE);

endmodule
